// File: rtl/sdram_port_ctrl.sv
// sdram_port_ctrl: round-robin write/read burst scheduler between frame FIFOs and an SDRAM user port
module sdram_port_ctrl #(
  parameter int BURST_MAX = 512
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst,
  input  logic        i_init_done,
  input  logic [23:0] i_wr_b_addr,
  input  logic [23:0] i_wr_e_addr,
  input  logic [23:0] i_rd_b_addr,
  input  logic [23:0] i_rd_e_addr,
  input  logic [9:0]  i_wr_burst_len,
  input  logic [9:0]  i_rd_burst_len,
  input  logic        i_wr_addr_rst,
  input  logic        i_rd_addr_rst,
  input  logic        i_rd_en,
  input  logic [9:0]  i_wfifo_usedw,
  input  logic [15:0] i_wfifo_data,
  output logic        o_wfifo_rd_en,
  input  logic [9:0]  i_rfifo_usedw,
  output logic        o_rfifo_wr_en,
  output logic [15:0] o_rfifo_data,
  output logic        o_wr_req,
  output logic [23:0] o_wr_addr,
  output logic [9:0]  o_wr_burst_len,
  output logic [15:0] o_wr_data,
  input  logic        i_wr_ack,
  output logic        o_rd_req,
  output logic [23:0] o_rd_addr,
  output logic [9:0]  o_rd_burst_len,
  input  logic [15:0] i_rd_data,
  input  logic        i_rd_ack
);
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  localparam logic [9:0] BMAX = 10'(BURST_MAX);
  state_t state;
  logic [23:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [9:0] wr_len, rd_len;
  logic wr_rst_pend, rd_rst_pend, last_wr, wr_ack_q, rd_ack_q;
  logic wr_pend, rd_pend, wr_done, rd_done, wr_wrap, rd_wrap;
  assign o_wr_data = i_wfifo_data;
  assign o_wfifo_rd_en = i_wr_ack;
  assign o_rfifo_data = i_rd_data;
  assign o_rfifo_wr_en = i_rd_ack;
  assign wr_len = (i_wr_burst_len > BMAX) ? BMAX : i_wr_burst_len;
  assign rd_len = (i_rd_burst_len > BMAX) ? BMAX : i_rd_burst_len;
  assign wr_pend = i_init_done && (i_wfifo_usedw >= wr_len);
  assign rd_pend = i_init_done && i_rd_en && (i_rfifo_usedw < rd_len);
  assign wr_done = wr_ack_q && !i_wr_ack;
  assign rd_done = rd_ack_q && !i_rd_ack;
  assign wr_nxt = wr_ptr + 24'(o_wr_burst_len);
  assign rd_nxt = rd_ptr + 24'(o_rd_burst_len);
  // 25-bit compare so pointer + length can never overflow the check
  assign wr_wrap = ({1'b0, wr_nxt} + 25'(o_wr_burst_len)) > {1'b0, i_wr_e_addr};
  assign rd_wrap = ({1'b0, rd_nxt} + 25'(o_rd_burst_len)) > {1'b0, i_rd_e_addr};
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      state <= IDLE;
      o_wr_req <= 1'b0;
      o_rd_req <= 1'b0;
      o_wr_addr <= '0;
      o_rd_addr <= '0;
      o_wr_burst_len <= '0;
      o_rd_burst_len <= '0;
      wr_ptr <= i_wr_b_addr;
      rd_ptr <= i_rd_b_addr;
      wr_rst_pend <= 1'b0;
      rd_rst_pend <= 1'b0;
      last_wr <= 1'b0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= (state == WR) && i_wr_ack;
      rd_ack_q <= (state == RD) && i_rd_ack;
      if (i_wr_addr_rst && state != WR) wr_ptr <= i_wr_b_addr;
      if (i_rd_addr_rst && state != RD) rd_ptr <= i_rd_b_addr;
      case (state)
        IDLE: begin
          if (wr_pend && (!rd_pend || !last_wr)) begin
            state <= WR;
            o_wr_req <= 1'b1;
            o_wr_addr <= i_wr_addr_rst ? i_wr_b_addr : wr_ptr;
            o_wr_burst_len <= wr_len;
            last_wr <= 1'b1;
          end else if (rd_pend) begin
            state <= RD;
            o_rd_req <= 1'b1;
            o_rd_addr <= i_rd_addr_rst ? i_rd_b_addr : rd_ptr;
            o_rd_burst_len <= rd_len;
            last_wr <= 1'b0;
          end
        end
        WR: begin
          if (i_wr_addr_rst) wr_rst_pend <= 1'b1;
          if (wr_done) begin
            state <= IDLE;
            o_wr_req <= 1'b0;
            wr_ptr <= (wr_rst_pend || i_wr_addr_rst || wr_wrap) ? i_wr_b_addr : wr_nxt;
            wr_rst_pend <= 1'b0;
          end
        end
        RD: begin
          if (i_rd_addr_rst) rd_rst_pend <= 1'b1;
          if (rd_done) begin
            state <= IDLE;
            o_rd_req <= 1'b0;
            rd_ptr <= (rd_rst_pend || i_rd_addr_rst || rd_wrap) ? i_rd_b_addr : rd_nxt;
            rd_rst_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_port_ctrl.sv
// tb_sdram_port_ctrl: table vectors, directed burst sequences and a randomized run against a pointer/arbitration model
module tb_sdram_port_ctrl;
  logic i_sysclk, i_sysrst, i_init_done;
  logic [23:0] i_wr_b_addr, i_wr_e_addr, i_rd_b_addr, i_rd_e_addr;
  logic [9:0] i_wr_burst_len, i_rd_burst_len, i_wfifo_usedw, i_rfifo_usedw;
  logic i_wr_addr_rst, i_rd_addr_rst, i_rd_en, i_wr_ack, i_rd_ack;
  logic [15:0] i_wfifo_data, i_rd_data, o_rfifo_data, o_wr_data;
  logic o_wfifo_rd_en, o_rfifo_wr_en, o_wr_req, o_rd_req;
  logic [23:0] o_wr_addr, o_rd_addr;
  logic [9:0] o_wr_burst_len, o_rd_burst_len;
  int n_chk = 0, n_fail = 0;
  int n_pop = 0, n_push = 0, n_bad = 0;
  bit both_seen = 0;

  sdram_port_ctrl #(.BURST_MAX(512)) dut (
    .i_sysclk(i_sysclk), .i_sysrst(i_sysrst), .i_init_done(i_init_done),
    .i_wr_b_addr(i_wr_b_addr), .i_wr_e_addr(i_wr_e_addr),
    .i_rd_b_addr(i_rd_b_addr), .i_rd_e_addr(i_rd_e_addr),
    .i_wr_burst_len(i_wr_burst_len), .i_rd_burst_len(i_rd_burst_len),
    .i_wr_addr_rst(i_wr_addr_rst), .i_rd_addr_rst(i_rd_addr_rst), .i_rd_en(i_rd_en),
    .i_wfifo_usedw(i_wfifo_usedw), .i_wfifo_data(i_wfifo_data), .o_wfifo_rd_en(o_wfifo_rd_en),
    .i_rfifo_usedw(i_rfifo_usedw), .o_rfifo_wr_en(o_rfifo_wr_en), .o_rfifo_data(o_rfifo_data),
    .o_wr_req(o_wr_req), .o_wr_addr(o_wr_addr), .o_wr_burst_len(o_wr_burst_len),
    .o_wr_data(o_wr_data), .i_wr_ack(i_wr_ack),
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .o_rd_burst_len(o_rd_burst_len),
    .i_rd_data(i_rd_data), .i_rd_ack(i_rd_ack)
  );

  initial i_sysclk = 0;
  always #5 i_sysclk = ~i_sysclk;

  always @(posedge i_sysclk) begin
    if (o_wfifo_rd_en) n_pop <= n_pop + 1;
    if (o_rfifo_wr_en) n_push <= n_push + 1;
    if (o_rfifo_wr_en && o_rfifo_data !== i_rd_data) n_bad <= n_bad + 1;
  end
  always @(negedge i_sysclk) if (o_wr_req && o_rd_req) both_seen <= 1;

  typedef struct {
    bit init, rd_en;
    logic [9:0] wu, ru, wl, rl;
    bit exp_w, exp_r;
  } dec_vec_t;
  typedef struct {
    bit wack, rack;
    logic [15:0] wd, rd;
  } dp_vec_t;
  dec_vec_t dv[8];
  dp_vec_t pv[4];

  task automatic tick();
    @(posedge i_sysclk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    i_sysrst = 1;
    tick();
    i_sysrst = 0;
  endtask

  task automatic wait_any(output bit wr, output bit ok);
    ok = 0;
    wr = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_wr_req || o_rd_req) begin
        ok = 1;
        wr = o_wr_req;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL req_timeout: got no request expected one at %0t", $time);
    end
  endtask

  task automatic serve(input bit wr, input int len, input int lat, input bit rst_mid);
    logic [23:0] a0;
    a0 = wr ? o_wr_addr : o_rd_addr;
    repeat (lat) tick();
    for (int i = 0; i < len; i++) begin
      if (wr) i_wr_ack = 1; else i_rd_ack = 1;
      i_wfifo_data = 16'($urandom);
      i_rd_data = 16'($urandom);
      if (wr) i_wr_addr_rst = rst_mid && i == len / 2;
      else i_rd_addr_rst = rst_mid && i == len / 2;
      tick();
    end
    i_wr_addr_rst = 0;
    i_rd_addr_rst = 0;
    check("addr_hold", 32'(wr ? o_wr_addr : o_rd_addr), 32'(a0));
    check("req_before_done", 32'(wr ? o_wr_req : o_rd_req), 1);
    i_wr_ack = 0;
    i_rd_ack = 0;
    tick();
    check("req_after_done", 32'(wr ? o_wr_req : o_rd_req), 0);
  endtask

  initial begin
    bit side, ok, acc;
    int p0;
    i_sysrst = 1; i_init_done = 0; i_rd_en = 0;
    i_wr_b_addr = 0; i_wr_e_addr = 24'h400; i_rd_b_addr = 0; i_rd_e_addr = 24'h400;
    i_wr_burst_len = 256; i_rd_burst_len = 128; i_wfifo_usedw = 0; i_rfifo_usedw = 0;
    i_wr_addr_rst = 0; i_rd_addr_rst = 0; i_wr_ack = 0; i_rd_ack = 0;
    i_wfifo_data = 0; i_rd_data = 0;
    dv[0] = '{1, 0, 256, 0,   256, 128, 1, 0};
    dv[1] = '{1, 0, 255, 0,   256, 128, 0, 0};
    dv[2] = '{1, 1, 0,   127, 256, 128, 0, 1};
    dv[3] = '{1, 1, 0,   128, 256, 128, 0, 0};
    dv[4] = '{1, 1, 300, 0,   256, 128, 1, 0};
    dv[5] = '{0, 1, 300, 0,   256, 128, 0, 0};
    dv[6] = '{1, 0, 0,   0,   256, 128, 0, 0};
    dv[7] = '{1, 1, 1,   0,   1,   1,   1, 0};
    pv[0] = '{1, 0, 16'hA5A5, 16'h1234};
    pv[1] = '{0, 1, 16'h0F0F, 16'hBEEF};
    pv[2] = '{1, 1, 16'hFFFF, 16'h0000};
    pv[3] = '{0, 0, 16'h0001, 16'h8000};
    tick(); tick();
    do_reset();
    check("reset_wr_req", 32'(o_wr_req), 0);
    check("reset_rd_req", 32'(o_rd_req), 0);

    // arbitration decision table, fresh reset per vector
    for (int i = 0; i < 8; i++) begin
      do_reset();
      i_init_done = dv[i].init; i_rd_en = dv[i].rd_en;
      i_wfifo_usedw = dv[i].wu; i_rfifo_usedw = dv[i].ru;
      i_wr_burst_len = dv[i].wl; i_rd_burst_len = dv[i].rl;
      tick();
      check($sformatf("dec%0d_wr_req", i), 32'(o_wr_req), 32'(dv[i].exp_w));
      check($sformatf("dec%0d_rd_req", i), 32'(o_rd_req), 32'(dv[i].exp_r));
    end

    // combinational data paths while idle
    i_init_done = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      i_wr_ack = pv[i].wack; i_rd_ack = pv[i].rack;
      i_wfifo_data = pv[i].wd; i_rd_data = pv[i].rd;
      #1;
      check($sformatf("dp%0d_wfifo_rd_en", i), 32'(o_wfifo_rd_en), 32'(pv[i].wack));
      check($sformatf("dp%0d_rfifo_wr_en", i), 32'(o_rfifo_wr_en), 32'(pv[i].rack));
      check($sformatf("dp%0d_wr_data", i), 32'(o_wr_data), 32'(pv[i].wd));
      check($sformatf("dp%0d_rfifo_data", i), 32'(o_rfifo_data), 32'(pv[i].rd));
    end
    i_wr_ack = 0; i_rd_ack = 0;
    tick();

    // single writes stepping through the region, then wrap
    i_init_done = 1; i_rd_en = 0; i_wr_b_addr = 0; i_wr_e_addr = 24'h400;
    i_wr_burst_len = 256; i_wfifo_usedw = 0;
    do_reset();
    i_wfifo_usedw = 256;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("wr%0d_req", k), 32'(o_wr_req), 1);
      check($sformatf("wr%0d_addr", k), 32'(o_wr_addr), (k == 4) ? 0 : k * 32'h100);
      check($sformatf("wr%0d_len", k), 32'(o_wr_burst_len), 256);
      p0 = n_pop;
      serve(1, 256, 0, 0);
      check($sformatf("wr%0d_pops", k), 32'(n_pop - p0), 256);
    end

    // contention alternates starting with write
    i_wr_burst_len = 16; i_rd_burst_len = 16; i_wfifo_usedw = 100;
    i_rd_en = 1; i_rfifo_usedw = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      wait_any(side, ok);
      check($sformatf("rr%0d_side", k), 32'(side), (k % 2 == 0) ? 1 : 0);
      if (ok) serve(side, 16, 1, 0);
    end

    // read refill
    i_wfifo_usedw = 0; i_rd_en = 1; i_rfifo_usedw = 100; i_rd_burst_len = 128;
    i_rd_b_addr = 24'h200; i_rd_e_addr = 24'h10000;
    do_reset();
    tick();
    check("refill_req", 32'(o_rd_req), 1);
    check("refill_addr", 32'(o_rd_addr), 32'h200);
    check("refill_len", 32'(o_rd_burst_len), 128);
    p0 = n_push;
    serve(0, 128, 2, 0);
    check("refill_pushes", 32'(n_push - p0), 128);
    check("refill_data", 32'(n_bad), 0);

    // read pointer reload requested mid burst
    i_rd_b_addr = 0; i_rd_e_addr = 24'h1000; i_rd_burst_len = 24'h100; i_rfifo_usedw = 0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rrst%0d_addr", k), 32'(o_rd_addr), k * 32'h100);
      serve(0, 256, 0, k == 2);
    end
    tick();
    check("rrst_next_req", 32'(o_rd_req), 1);
    check("rrst_next_addr", 32'(o_rd_addr), 0);

    // reset during an active write burst
    i_rd_en = 0; i_wr_b_addr = 24'h40; i_wr_e_addr = 24'h1000; i_wr_burst_len = 16;
    i_wfifo_usedw = 16;
    do_reset();
    tick();
    serve(1, 16, 0, 0);
    tick();
    check("rstmid_addr2", 32'(o_wr_addr), 32'h50);
    i_wr_ack = 1;
    repeat (3) tick();
    i_sysrst = 1;
    tick();
    check("rstmid_req_drop", 32'(o_wr_req), 0);
    tick();
    i_sysrst = 0; i_wfifo_usedw = 0;
    tick();
    i_wr_ack = 0;
    tick();
    check("rstmid_quiet_wr", 32'(o_wr_req), 0);
    check("rstmid_quiet_rd", 32'(o_rd_req), 0);
    i_wfifo_usedw = 16;
    tick();
    check("rstmid_new_req", 32'(o_wr_req), 1);
    check("rstmid_ptr_reload", 32'(o_wr_addr), 32'h40);

    // init_done low blocks everything
    i_init_done = 0; i_wfifo_usedw = 300; i_wr_burst_len = 256;
    i_rd_en = 1; i_rfifo_usedw = 0; i_rd_burst_len = 128;
    do_reset();
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      acc |= o_wr_req | o_rd_req;
      tick();
    end
    check("noinit_no_req", 32'(acc), 0);
    i_init_done = 1;
    tick();
    check("init_release_req", 32'(o_wr_req), 1);

    // randomized phases against the reference model
    begin
      int wb, we, rb, re, m_wp, m_rp, wl, rl, k, lat, ea;
      bit m_last_wr, wp, rp, exp_wr, pw, pr, rm;
      wb = 24'h1000; we = wb + 200; rb = 24'h8000; re = rb + 300;
      i_wr_b_addr = 24'(wb); i_wr_e_addr = 24'(we);
      i_rd_b_addr = 24'(rb); i_rd_e_addr = 24'(re);
      i_init_done = 1; i_rd_en = 1; i_wfifo_usedw = 0; i_rfifo_usedw = 1023;
      do_reset();
      m_wp = wb; m_rp = rb; m_last_wr = 0;
      for (int ph = 0; ph < 40; ph++) begin
        wl = $urandom_range(1, 64); rl = $urandom_range(1, 64);
        k = $urandom_range(0, 2);
        wp = (k != 1); rp = (k != 0);
        i_wr_burst_len = 10'(wl); i_rd_burst_len = 10'(rl);
        i_wfifo_usedw = 10'(wp ? wl + $urandom_range(0, 20) : wl - 1);
        i_rfifo_usedw = 10'(rp ? $urandom_range(0, rl - 1) : rl + $urandom_range(0, 10));
        pw = ($urandom_range(0, 7) == 0); pr = ($urandom_range(0, 7) == 0);
        i_wr_addr_rst = pw; i_rd_addr_rst = pr;
        if (pw) m_wp = wb;
        if (pr) m_rp = rb;
        exp_wr = wp && (!rp || !m_last_wr);
        tick();
        i_wr_addr_rst = 0; i_rd_addr_rst = 0;
        wait_any(side, ok);
        if (!ok) break;
        ea = exp_wr ? m_wp : m_rp;
        check($sformatf("rnd%0d_side", ph), 32'(side), 32'(exp_wr));
        check($sformatf("rnd%0d_addr", ph), 32'(side ? o_wr_addr : o_rd_addr), 32'(ea));
        check($sformatf("rnd%0d_len", ph), 32'(side ? o_wr_burst_len : o_rd_burst_len),
              32'(exp_wr ? wl : rl));
        lat = $urandom_range(0, 3);
        rm = ($urandom_range(0, 5) == 0);
        serve(side, side ? wl : rl, lat, rm);
        if (exp_wr) m_wp = (rm || m_wp + 2 * wl > we) ? wb : m_wp + wl;
        else m_rp = (rm || m_rp + 2 * rl > re) ? rb : m_rp + rl;
        m_last_wr = exp_wr;
      end
    end

    check("req_mutex", 32'(both_seen), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_port_ctrl.md
SDRAM_PORT_CTRL -- requirements
Module: sdram_port_ctrl

Interface
REQ-001 Parameter BURST_MAX, default 512: largest legal burst length; i_wr_burst_len and i_rd_burst_len SHALL be in 1..BURST_MAX.
REQ-002 i_sysclk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-003 i_sysrst  in  1  synchronous, active-high reset.
REQ-004 i_init_done  in  1  SDRAM initialisation complete.
REQ-005 i_wr_b_addr / i_wr_e_addr  in  24 each  write region begin address (inclusive) and end address (exclusive).
REQ-006 i_rd_b_addr / i_rd_e_addr  in  24 each  read region begin address (inclusive) and end address (exclusive).
REQ-007 i_wr_burst_len / i_rd_burst_len  in  10 each  words per burst.
REQ-008 i_wr_addr_rst / i_rd_addr_rst  in  1 each  pulse: reload the pointer to its begin address.
REQ-009 i_rd_en  in  1  read-side service enable (display active).
REQ-010 i_wfifo_usedw  in  10  write-FIFO fill level; i_wfifo_data  in  16  show-ahead write-FIFO output; o_wfifo_rd_en  out  1  write-FIFO pop.
REQ-011 i_rfifo_usedw  in  10  read-FIFO fill level; o_rfifo_wr_en  out  1  read-FIFO push; o_rfifo_data  out  16  read-FIFO push data.
REQ-012 o_wr_req  out  1, o_wr_addr  out  24, o_wr_burst_len  out  10, o_wr_data  out  16, i_wr_ack  in  1: SDRAM write user port.
REQ-013 o_rd_req  out  1, o_rd_addr  out  24, o_rd_burst_len  out  10, i_rd_data  in  16, i_rd_ack  in  1: SDRAM read user port.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WR and RD.
REQ-015 Write-pending SHALL be defined as i_init_done && (i_wfifo_usedw >= i_wr_burst_len).
REQ-016 Read-pending SHALL be defined as i_init_done && i_rd_en && (i_rfifo_usedw < i_rd_burst_len).
REQ-017 In IDLE, only write-pending SHALL select WR, only read-pending SHALL select RD, and both SHALL select the side not serviced last (round-robin; write wins on the first tie after reset).
REQ-018 The selected o_*_req SHALL assert on the cycle after the decision and hold high until burst completion.
REQ-019 o_wr_addr/o_wr_burst_len and o_rd_addr/o_rd_burst_len SHALL be registered at request assertion and held stable while the request is high.
REQ-020 Write data path: o_wr_data SHALL equal i_wfifo_data combinationally, and o_wfifo_rd_en SHALL equal i_wr_ack combinationally.
REQ-021 Read data path: o_rfifo_wr_en SHALL equal i_rd_ack, and o_rfifo_data SHALL equal i_rd_data, both combinationally.
REQ-022 Burst completion SHALL be detected on the cycle where the ack was 1 on the previous cycle and is 0 now (falling edge).
REQ-023 On burst completion the request SHALL deassert, the FSM SHALL return to IDLE, and the pointer SHALL advance by the burst length.
REQ-024 If the advanced pointer + burst length > the end address, the pointer SHALL wrap to the begin address.
REQ-025 Pointer arithmetic SHALL be 24-bit unsigned; the compare SHALL be at 25 bits so it never overflows.
REQ-026 An i_*_addr_rst pulse received in IDLE, or for the other side, SHALL reload that pointer to its begin address on the next cycle.
REQ-027 An i_*_addr_rst pulse received during that side's active burst SHALL be latched and applied at completion instead of the advance.
REQ-028 i_init_done low SHALL prevent new requests; an in-progress burst SHALL still run to completion.
REQ-029 A request SHALL never be issued in the cycle that completion is detected; the minimum request-low gap SHALL be 1 cycle.
REQ-030 At most one of o_wr_req and o_rd_req SHALL be high at any time.

Reset
REQ-031 On i_sysrst the FSM SHALL go to IDLE, o_wr_req and o_rd_req SHALL go to 0, the pointers SHALL load i_wr_b_addr and i_rd_b_addr, latched reloads SHALL clear, and the round-robin state SHALL be set to "read last".
REQ-032 Reset asserted mid-burst SHALL drop the request on the next edge; any further ack SHALL be ignored until IDLE re-evaluates after reset release.

Verification
REQ-033 Single write: init_done=1, wr_b=0, wr_e=0x400, wr_len=256, wfifo_usedw=256 -> o_wr_req high one cycle later at addr 0; ack for 256 cycles -> 256 wfifo pops; req falls at ack fall; next request addr 0x100.
REQ-034 Wrap: pointer at 0x300, len 256, e=0x400 -> burst at 0x300; next burst SHALL be at 0x000.
REQ-035 Contention: write- and read-pending both held high -> bursts alternate WR, RD, WR, RD, with o_wr_req and o_rd_req never high together.
REQ-036 Read refill: i_rd_en=1, rfifo_usedw=100, rd_len=128 -> o_rd_req high; 128 ack cycles produce 128 o_rfifo_wr_en pulses carrying i_rd_data unchanged.
REQ-037 i_rd_addr_rst pulsed mid read burst at 0x200 -> that burst completes at 0x200; the following read request SHALL be at rd_b.
REQ-038 i_sysrst during a write burst (ack high) -> o_wr_req=0 next cycle and the pointer returns to wr_b; i_init_done=0 with FIFOs pending -> no request ever asserted.
